// File: rtl/hamming_2d_stream_encoder.sv
// Streaming 2D Hamming encoder: buffers up to four 11-bit rows, row-encodes
// each with Hamming (15,11), interleaves the 4x15 array into 15 columns and
// emits each column (optionally Hamming (7,4) encoded) in groups of
// COLS_PER_BEAT columns per output beat.
module hamming_2d_stream_encoder #(
    parameter int COLS_PER_BEAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       col_en,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [10:0]                s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7*COLS_PER_BEAT-1:0] m_data,
    output logic                       m_last
);

    localparam int BEATS = 15 / COLS_PER_BEAT;
    localparam int GW    = 7 * COLS_PER_BEAT;

    if (!(COLS_PER_BEAT == 1 || COLS_PER_BEAT == 3 ||
          COLS_PER_BEAT == 5 || COLS_PER_BEAT == 15)) begin : g_bad_cols
        $error("COLS_PER_BEAT must be 1, 3, 5 or 15");
    end

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic [GW-1:0]    m_data_q;
    logic             col_en_q, col_en_d;
    logic [1:0]       row_cnt_q;
    logic [3:0]       beat_q, beat_d;
    logic [3:0][14:0] rows_q, rows_d;
    logic [GW-1:0]    grp_d;
    logic             s_fire, m_fire, fill_done;

    // Hamming (15,11): data at positions 3,5,6,7,9..15; even parity at 1,2,4,8.
    function automatic logic [14:0] ham15(input logic [10:0] d);
        logic [14:0] c;
        c = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
        c[0] = ^(c & 15'h5555);
        c[1] = ^(c & 15'h6666);
        c[3] = ^(c & 15'h7878);
        c[7] = ^(c & 15'h7F80);
        return c;
    endfunction

    // Hamming (7,4): data at positions 3,5,6,7; even parity at 1,2,4.
    function automatic logic [6:0] ham7(input logic [3:0] d);
        logic [6:0] c;
        c = {d[3:1], 1'b0, d[0], 2'b00};
        c[0] = ^(c & 7'h55);
        c[1] = ^(c & 7'h66);
        c[3] = ^(c & 7'h78);
        return c;
    endfunction

    // Column word group for one beat; column j nibble bit k is row k codeword bit j.
    function automatic logic [GW-1:0] col_group(input logic [3:0][14:0] rows,
                                                input logic [3:0] beat,
                                                input logic ce);
        logic [GW-1:0] g;
        logic [3:0]    nib;
        logic [3:0]    col;
        g = '0;
        for (int i = 0; i < COLS_PER_BEAT; i++) begin
            col = beat * 4'(COLS_PER_BEAT) + 4'(i);
            for (int k = 0; k < 4; k++) nib[k] = rows[k][col];
            g[7*i +: 7] = ce ? ham7(nib) : {3'b000, nib};
        end
        return g;
    endfunction

    assign s_fire    = s_valid && s_ready_q;
    assign m_fire    = m_valid_q && m_ready;
    assign fill_done = s_fire && (s_last || row_cnt_q == 2'd3);

    // Row buffer write: encode the accepted row, zero-fill the tail on early s_last.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path infers a latch.
        rows_d   = rows_q;
        col_en_d = col_en_q;
        if (s_fire) begin
            if (row_cnt_q == 2'd0) col_en_d = col_en;
            for (int k = 0; k < 4; k++) begin
                if (2'(k) == row_cnt_q)                rows_d[k] = ham15(s_data);
                else if (2'(k) > row_cnt_q && s_last) rows_d[k] = '0;
            end
        end
    end

    // Next beat to present and its column group, taken from the post-write buffer
    // so beat 0 is ready on the cycle right after the last row is accepted.
    always_comb begin
        if (state_q == FILL)                beat_d = '0;
        else if (beat_q == 4'(BEATS - 1))  beat_d = beat_q;
        else                                beat_d = beat_q + 4'd1;
        grp_d = col_group(rows_d, beat_d, col_en_d);
    end

    // Block FSM: FILL collects rows, DRAIN emits beats with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            col_en_q  <= 1'b0;
            row_cnt_q <= '0;
            beat_q    <= '0;
            // NOTE: the row buffer is cleared on reset too, so a discarded partial
            // block can never leak into the next one.
            rows_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples
            // the pre-edge values regardless of statement order.
            rows_q   <= rows_d;
            col_en_q <= col_en_d;
            case (state_q)
                FILL: begin
                    s_ready_q <= 1'b1;
                    if (s_fire) row_cnt_q <= row_cnt_q + 2'd1;
                    if (fill_done) begin
                        state_q   <= DRAIN;
                        s_ready_q <= 1'b0;
                        row_cnt_q <= '0;
                        beat_q    <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= grp_d;
                        m_last_q  <= (BEATS == 1);
                    end
                end
                DRAIN: begin
                    if (m_fire) begin
                        if (m_last_q) begin
                            state_q   <= FILL;
                            s_ready_q <= 1'b1;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            beat_q    <= '0;
                        end else begin
                            beat_q   <= beat_d;
                            m_data_q <= grp_d;
                            m_last_q <= (beat_d == 4'(BEATS - 1));
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_hamming_2d_stream_encoder.sv
// Directed bench for hamming_2d_stream_encoder: three instances (1, 5 and 15
// columns per beat) share the input bus; sel picks the one being exercised.
module tb_hamming_2d_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        col_en, s_valid, s_last, m_ready;
    logic [10:0] s_data;
    int          sel;
    int          n_cmp = 0;
    int          n_err = 0;

    logic         s_ready1, m_valid1, m_last1;
    logic [6:0]   m_data1;
    logic         s_ready5, m_valid5, m_last5;
    logic [34:0]  m_data5;
    logic         s_ready15, m_valid15, m_last15;
    logic [104:0] m_data15;

    logic         obs_s_ready, obs_m_valid, obs_m_last;
    logic [104:0] obs_m_data;

    always #5 clk = ~clk;

    hamming_2d_stream_encoder #(.COLS_PER_BEAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .col_en(col_en), .s_valid(s_valid && sel == 1),
        .s_ready(s_ready1), .s_data(s_data), .s_last(s_last), .m_valid(m_valid1),
        .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1));

    hamming_2d_stream_encoder #(.COLS_PER_BEAT(5)) u_dut5 (
        .clk(clk), .rst(rst), .col_en(col_en), .s_valid(s_valid && sel == 5),
        .s_ready(s_ready5), .s_data(s_data), .s_last(s_last), .m_valid(m_valid5),
        .m_ready(m_ready), .m_data(m_data5), .m_last(m_last5));

    hamming_2d_stream_encoder #(.COLS_PER_BEAT(15)) u_dut15 (
        .clk(clk), .rst(rst), .col_en(col_en), .s_valid(s_valid && sel == 15),
        .s_ready(s_ready15), .s_data(s_data), .s_last(s_last), .m_valid(m_valid15),
        .m_ready(m_ready), .m_data(m_data15), .m_last(m_last15));

    // Route the selected instance onto the observation bus.
    always_comb begin
        case (sel)
            5: begin
                obs_s_ready = s_ready5;  obs_m_valid = m_valid5;
                obs_m_last  = m_last5;   obs_m_data  = 105'(m_data5);
            end
            15: begin
                obs_s_ready = s_ready15; obs_m_valid = m_valid15;
                obs_m_last  = m_last15;  obs_m_data  = m_data15;
            end
            default: begin
                obs_s_ready = s_ready1;  obs_m_valid = m_valid1;
                obs_m_last  = m_last1;   obs_m_data  = 105'(m_data1);
            end
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference code: generic position-indexed Hamming, independent of the RTL masks.
    function automatic logic [14:0] m_ham15(input logic [10:0] d);
        logic [14:0] c;
        int n;
        logic x;
        c = '0;
        n = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin c[p-1] = d[n]; n++; end
        for (int k = 0; k < 4; k++) begin
            x = 1'b0;
            for (int p = 1; p <= 15; p++) if (((p >> k) & 1) == 1) x ^= c[p-1];
            c[(1 << k) - 1] = x;
        end
        return c;
    endfunction

    function automatic logic [6:0] m_ham7(input logic [3:0] d);
        logic [6:0] c;
        int n;
        logic x;
        c = '0;
        n = 0;
        for (int p = 1; p <= 7; p++)
            if ((p & (p - 1)) != 0) begin c[p-1] = d[n]; n++; end
        for (int k = 0; k < 3; k++) begin
            x = 1'b0;
            for (int p = 1; p <= 7; p++) if (((p >> k) & 1) == 1) x ^= c[p-1];
            c[(1 << k) - 1] = x;
        end
        return c;
    endfunction

    function automatic logic [104:0] model_block(input logic [3:0][10:0] r, input int nrows,
                                                 input bit ce);
        logic [3:0][14:0] cw;
        logic [104:0]     o;
        logic [3:0]       nib;
        for (int k = 0; k < 4; k++) cw[k] = (k < nrows) ? m_ham15(r[k]) : 15'h0000;
        o = '0;
        for (int j = 0; j < 15; j++) begin
            for (int k = 0; k < 4; k++) nib[k] = cw[k][j];
            o[7*j +: 7] = ce ? m_ham7(nib) : {3'b000, nib};
        end
        return o;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_row(input logic [10:0] d, input bit last, input bit ce);
        int t;
        t = 0;
        s_valid = 1'b1; s_data = d; s_last = last; col_en = ce;
        while (!obs_s_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!obs_s_ready) check("send_row/ready_timeout", 128'(obs_s_ready), 128'(1'b1));
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_block(input logic [3:0][10:0] r, input int nrows, input bit ce,
                              input bit flip, input bit last_on_final);
        for (int k = 0; k < nrows; k++) begin
            bit lst, c;
            lst = (k == nrows - 1) && (nrows < 4 || last_on_final);
            c   = (k > 0 && flip) ? ~ce : ce;
            send_row(r[k], lst, c);
        end
    endtask

    // Accepts n_take beats, checking framing, stall stability and s_ready while draining.
    task automatic collect(input string tag, input int cpb, input int n_take, input bit stress,
                           output logic [104:0] blk);
        int beats, b, t;
        logic [104:0] held;
        bit stalled, bad_sready, bad_stable, bad_last, bad_valid;
        beats = 15 / cpb;
        b = 0; t = 0; held = '0; blk = '0;
        stalled = 0; bad_sready = 0; bad_stable = 0; bad_last = 0; bad_valid = 0;
        while (b < n_take && t < 3000) begin
            if (stress) begin
                m_ready = 1'($urandom_range(0, 1));
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 11'($urandom);
                col_en  = ~col_en;
            end else begin
                m_ready = 1'b1;
            end
            if (obs_m_valid) begin
                if (obs_s_ready) bad_sready = 1;
                if (stalled && obs_m_data !== held) bad_stable = 1;
                if (obs_m_last !== (b == beats - 1)) bad_last = 1;
                if (m_ready) begin
                    for (int i = 0; i < 7 * cpb; i++) blk[b*7*cpb + i] = obs_m_data[i];
                    b++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = obs_m_data;
                end
            end else begin
                bad_valid = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        check({tag, "/beats"}, 128'(b), 128'(n_take));
        check({tag, "/sready_in_drain"}, 128'(bad_sready), 128'(0));
        check({tag, "/stall_stable"}, 128'(bad_stable), 128'(0));
        check({tag, "/last_pos"}, 128'(bad_last), 128'(0));
        check({tag, "/valid_hold"}, 128'(bad_valid), 128'(0));
        if (n_take == beats) begin
            check({tag, "/valid_after"}, 128'(obs_m_valid), 128'(1'b0));
            check({tag, "/sready_after"}, 128'(obs_s_ready), 128'(1'b1));
        end
    endtask

    task automatic run_block(input string tag, input int cpb, input logic [3:0][10:0] r,
                             input int nrows, input bit ce, input bit flip,
                             input bit last_on_final, input bit stress,
                             input logic [104:0] exp);
        logic [104:0] blk;
        sel = cpb;
        send_block(r, nrows, ce, flip, last_on_final);
        check({tag, "/latency"}, 128'(obs_m_valid), 128'(1'b1));
        collect(tag, cpb, 15 / cpb, stress, blk);
        check({tag, "/data"}, 128'(blk), 128'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/s_ready"}, 128'(obs_s_ready), 128'(1'b0));
        check({tag, "/m_valid"}, 128'(obs_m_valid), 128'(1'b0));
        check({tag, "/m_last"},  128'(obs_m_last),  128'(1'b0));
        check({tag, "/m_data"},  128'(obs_m_data),  128'(0));
    endtask

    // Asynchronous reset pulse mid-cycle, checked before any clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "/s_ready_at_release"}, 128'(obs_s_ready), 128'(1'b0));
        @(posedge clk); #1;
        check({tag, "/s_ready_after"}, 128'(obs_s_ready), 128'(1'b1));
    endtask

    initial begin
        logic [3:0][10:0] r;
        logic [104:0]     e;
        logic [104:0]     blk;

        rst = 1'b1; sel = 1; col_en = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        check("reset/s_ready_at_release", 128'(obs_s_ready), 128'(1'b0));
        @(posedge clk); #1;
        check("reset/s_ready_after", 128'(obs_s_ready), 128'(1'b1));

        // All-zero block, full 2D code.
        r = '0;
        run_block("zero", 1, r, 4, 1'b1, 1'b0, 1'b0, 1'b0, 105'h0);

        // Single row 11'h001 with early s_last: codeword 15'h0007 in columns 0..2.
        r = '0; r[0] = 11'h001;
        run_block("short_col", 1, r, 1, 1'b1, 1'b0, 1'b0, 1'b0, 105'({7'h07, 7'h07, 7'h07}));
        run_block("short_row", 1, r, 1, 1'b0, 1'b0, 1'b0, 1'b0, 105'({7'h01, 7'h01, 7'h01}));

        // Row 11'h7FF alone encodes to 15'h7FFF: every column nibble is 4'b0001.
        r = '0; r[0] = 11'h7FF;
        for (int j = 0; j < 15; j++) e[7*j +: 7] = 7'h01;
        run_block("ones_row15", 15, r, 1, 1'b0, 1'b0, 1'b0, 1'b0, e);
        for (int j = 0; j < 15; j++) e[7*j +: 7] = 7'h07;
        run_block("ones_col15", 15, r, 1, 1'b1, 1'b0, 1'b0, 1'b0, e);

        // Full single-beat blocks against the reference code.
        r[0] = 11'h5A3; r[1] = 11'h7FF; r[2] = 11'h123; r[3] = 11'h400;
        run_block("full15_col", 15, r, 4, 1'b1, 1'b0, 1'b0, 1'b0, model_block(r, 4, 1'b1));
        run_block("full15_row", 15, r, 4, 1'b0, 1'b0, 1'b0, 1'b0, model_block(r, 4, 1'b0));

        // Three-beat blocks with stalls, then an early s_last over a dirty buffer.
        r[0] = 11'h2C9; r[1] = 11'h015; r[2] = 11'h6E0; r[3] = 11'h3B7;
        run_block("cpb5_stall", 5, r, 4, 1'b1, 1'b0, 1'b0, 1'b1, model_block(r, 4, 1'b1));
        r[0] = 11'h0F0; r[1] = 11'h70F;
        run_block("cpb5_short", 5, r, 2, 1'b1, 1'b0, 1'b0, 1'b0, model_block(r, 2, 1'b1));

        // Random backpressure, s_valid noise in DRAIN, col_en flipping, s_last on row 3.
        r[0] = 11'h155; r[1] = 11'h2AA; r[2] = 11'h631; r[3] = 11'h09C;
        run_block("cpb1_stress", 1, r, 4, 1'b1, 1'b1, 1'b1, 1'b1, model_block(r, 4, 1'b1));
        run_block("cpb1_stress0", 1, r, 4, 1'b0, 1'b1, 1'b0, 1'b1, model_block(r, 4, 1'b0));

        // Reset after two rows, then a clean block from row 0.
        sel = 1;
        send_row(11'h7AB, 1'b0, 1'b1);
        send_row(11'h3CD, 1'b0, 1'b1);
        pulse_reset("rst_fill");
        r[0] = 11'h111; r[1] = 11'h222; r[2] = 11'h444; r[3] = 11'h7FE;
        run_block("after_rst_fill", 1, r, 4, 1'b1, 1'b0, 1'b0, 1'b0, model_block(r, 4, 1'b1));

        // Reset after output beat 6, then a clean block.
        send_block(r, 4, 1'b1, 1'b0, 1'b0);
        collect("rst_drain_pre", 1, 7, 1'b0, blk);
        check("rst_drain_pre/partial", 128'(blk[48:0]), 128'(model_block(r, 4, 1'b1) & 105'h1_FFFF_FFFF_FFFF));
        pulse_reset("rst_drain");
        r[0] = 11'h6B5; r[1] = 11'h001; r[2] = 11'h7FF; r[3] = 11'h248;
        run_block("after_rst_drain", 1, r, 4, 1'b1, 1'b0, 1'b0, 1'b0, model_block(r, 4, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
